// File: rtl/async_fifo_flags.sv
// Dual-clock FIFO with Gray-coded pointer crossing, programmable almost-full /
// almost-empty thresholds, per-domain fill levels and overflow/underflow pulses.
// Define ASYNC_FIFO_FWFT_EN for first-word-fall-through read mode; the default
// build is standard mode (data_out loads on the edge that accepts r_en).
// rst is asynchronous, active-high, and clears both domains; its release must be
// synchronised to each clock outside this block. Memory is not cleared.

module async_fifo_flags #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AF_THRESH   = DEPTH - 2,
    parameter int unsigned AE_THRESH   = 2,
    localparam int unsigned AW         = $clog2(DEPTH)
) (
    input  logic             w_clk,
    input  logic             rst,
    input  logic             r_clk,
    // write domain
    input  logic             w_en,
    input  logic [WIDTH-1:0] data_in,
    output logic             full,
    output logic             almost_full,
    output logic [AW:0]      wr_level,
    output logic             wr_overflow,
    // read domain
    input  logic             r_en,
    output logic [WIDTH-1:0] data_out,
    output logic             empty,
    output logic             almost_empty,
    output logic [AW:0]      rd_level,
    output logic             rd_underflow
);

    localparam logic [AW:0] PtrOne  = (AW + 1)'(1);
    localparam logic [AW:0] AfLevel = (AW + 1)'(AF_THRESH);
    localparam logic [AW:0] AeLevel = (AW + 1)'(AE_THRESH);

    function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
        logic [AW:0] b;
        b[AW] = g[AW];
        for (int i = int'(AW) - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [WIDTH-1:0] mem [DEPTH];

    // Write-domain state
    logic [AW:0] w_bin_q, w_gray_q, w_bin_next;
    logic [AW:0] r_sync_q [SYNC_STAGES];
    logic [AW:0] r_sync, r_sync_bin;
    logic        w_push;
    logic        wr_overflow_q;

    // Read-domain state
    logic [AW:0]      r_bin_q, r_gray_q, r_bin_next;
    logic [AW:0]      w_sync_q [SYNC_STAGES];
    logic [AW:0]      w_sync, w_sync_bin, mem_level;
    logic             mem_empty;
    logic             mem_rd;
    logic             rd_underflow_q;
    logic [WIDTH-1:0] data_out_q;

    // ------------------------------------------------------------------
    // Write domain
    // ------------------------------------------------------------------
    assign r_sync     = r_sync_q[SYNC_STAGES-1];
    assign r_sync_bin = gray2bin(r_sync);
    // Full when the write pointer is exactly one lap ahead of the synced read pointer.
    assign full        = (w_gray_q == {~r_sync[AW:AW-1], r_sync[AW-2:0]});
    assign w_push      = w_en && !full;
    assign w_bin_next  = w_bin_q + PtrOne;
    assign wr_level    = w_bin_q - r_sync_bin;
    assign almost_full = (wr_level >= AfLevel);
    assign wr_overflow = wr_overflow_q;

    // Write pointer (binary and registered Gray copy) plus overflow pulse
    always_ff @(posedge w_clk or posedge rst) begin
        if (rst) begin
            w_bin_q       <= '0;
            w_gray_q      <= '0;
            wr_overflow_q <= 1'b0;
        end else begin
            if (w_push) begin
                w_bin_q  <= w_bin_next;
                w_gray_q <= bin2gray(w_bin_next);
            end
            wr_overflow_q <= w_en && full;
        end
    end

    // Bring the read pointer's Gray code into the write clock domain
    always_ff @(posedge w_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) r_sync_q[i] <= '0;
        end else begin
            r_sync_q[0] <= r_gray_q;
            for (int i = 1; i < int'(SYNC_STAGES); i++) r_sync_q[i] <= r_sync_q[i-1];
        end
    end

    // Storage write port
    always_ff @(posedge w_clk) begin
        if (w_push) mem[w_bin_q[AW-1:0]] <= data_in;
    end

    // ------------------------------------------------------------------
    // Read domain
    // ------------------------------------------------------------------
    assign w_sync       = w_sync_q[SYNC_STAGES-1];
    assign w_sync_bin   = gray2bin(w_sync);
    assign mem_empty    = (r_gray_q == w_sync);
    assign mem_level    = w_sync_bin - r_bin_q;
    assign r_bin_next   = r_bin_q + PtrOne;
    assign almost_empty = (rd_level <= AeLevel);
    assign rd_underflow = rd_underflow_q;
    assign data_out     = data_out_q;

`ifdef ASYNC_FIFO_FWFT_EN
    logic out_valid_q;

    // Refill the output register whenever it is vacant or being popped this edge.
    assign mem_rd   = !mem_empty && (!out_valid_q || r_en);
    assign empty    = !out_valid_q;
    assign rd_level = mem_level + {{AW{1'b0}}, out_valid_q};

    // Head-of-queue output register
    always_ff @(posedge r_clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
        end else if (mem_rd) begin
            out_valid_q <= 1'b1;
            data_out_q  <= mem[r_bin_q[AW-1:0]];
        end else if (r_en) begin
            out_valid_q <= 1'b0;
        end
    end
`else
    assign mem_rd   = r_en && !mem_empty;
    assign empty    = mem_empty;
    assign rd_level = mem_level;

    // Registered read data, held when no word is popped
    always_ff @(posedge r_clk or posedge rst) begin
        if (rst) begin
            data_out_q <= '0;
        end else if (mem_rd) begin
            data_out_q <= mem[r_bin_q[AW-1:0]];
        end
    end
`endif

    // Read pointer (binary and registered Gray copy) plus underflow pulse
    always_ff @(posedge r_clk or posedge rst) begin
        if (rst) begin
            r_bin_q        <= '0;
            r_gray_q       <= '0;
            rd_underflow_q <= 1'b0;
        end else begin
            if (mem_rd) begin
                r_bin_q  <= r_bin_next;
                r_gray_q <= bin2gray(r_bin_next);
            end
            rd_underflow_q <= r_en && empty;
        end
    end

    // Bring the write pointer's Gray code into the read clock domain
    always_ff @(posedge r_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) w_sync_q[i] <= '0;
        end else begin
            w_sync_q[0] <= w_gray_q;
            for (int i = 1; i < int'(SYNC_STAGES); i++) w_sync_q[i] <= w_sync_q[i-1];
        end
    end

endmodule
